// File: rtl/nbbpu_pkg.sv
// nbbpu_pkg: shared widths, opcode map and fetch FSM encoding for the NBBPU core.
package nbbpu_pkg;

    localparam int ADDR_WIDTH   = 16;
    localparam int INSTR_WIDTH  = 16;
    localparam int OPCODE_WIDTH = 4;

    // Opcode field, instruction[15:12].
    typedef enum logic [OPCODE_WIDTH-1:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_MUL = 4'h2,
        OP_AND = 4'h3,
        OP_OR  = 4'h4,
        OP_XOR = 4'h5,
        OP_NOT = 4'h6,
        OP_SHL = 4'h7,
        OP_SHR = 4'h8,
        OP_LOD = 4'h9,
        OP_STR = 4'hA,
        OP_SEU = 4'hB,
        OP_JMP = 4'hC,
        OP_BRE = 4'hD,
        OP_BRN = 4'hE,
        OP_RES = 4'hF
    } opcode_e;

    // Fetch front-end sequencing.
    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } fetch_state_e;

    // 16-bit counter step that sticks at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value, input logic en);
        return (en && (value != 16'hFFFF)) ? value + 16'd1 : value;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: DEPTH-entry synchronous FIFO of {address, instruction} pairs.
// clear has priority over push and pop; push into a full buffer is accepted
// only together with a pop.
module fetch_buffer #(
    parameter int DEPTH = 2,
    parameter int AW    = 16,
    parameter int IW    = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [AW-1:0]              push_addr,
    input  logic [IW-1:0]              push_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [AW-1:0]              head_addr,
    output logic [IW-1:0]              head_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW+IW-1:0] entry_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign {head_addr, head_data} = entry_q[rd_ptr_q];

    // Next pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        // NOTE: every _d gets its hold value first so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_d = count_q + 1'b1;
            else if (do_pop && !do_push) count_d = count_q - 1'b1;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage write port.
    always_ff @(posedge clock) begin
        // NOTE: storage has no reset; count_q == 0 already marks every entry as invalid.
        if (do_push && !clear) entry_q[wr_ptr_q] <= {push_addr, push_data};
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: NBBPU instruction fetch front-end. Issues sequential requests to
// instruction memory, buffers responses and hands them to decode over
// valid/ready; a taken jump/branch (PC_select on a handshake) flushes and redirects.
// Optional macro FETCH_PERF_EN adds saturating fetch_count / flush_count outputs.
module fetch_unit #(
    parameter int                    ADDR_WIDTH  = nbbpu_pkg::ADDR_WIDTH,
    parameter int                    INSTR_WIDTH = nbbpu_pkg::INSTR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    DEPTH       = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic [ADDR_WIDTH-1:0]  instr_addr,
    output logic                   instr_req,
    input  logic [INSTR_WIDTH-1:0] instr_rdata,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic [3:0]             opcode,
    output logic [ADDR_WIDTH-1:0]  instr_PC,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    input  logic                   PC_select,
    input  logic [ADDR_WIDTH-1:0]  jump_target
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]            fetch_count,
    output logic [15:0]            flush_count
`endif
);

    import nbbpu_pkg::*;

    localparam int CW = $clog2(DEPTH+1);

    fetch_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0]  inflight_addr_q, inflight_addr_d;
    logic                   inflight_q, inflight_d;
    logic                   drop_q, drop_d;
    logic [INSTR_WIDTH-1:0] hold_instr_q, hold_instr_d;
    logic [ADDR_WIDTH-1:0]  hold_pc_q, hold_pc_d;

    logic                   buf_full, buf_empty;
    logic [CW-1:0]          buf_count;
    logic [ADDR_WIDTH-1:0]  head_addr;
    logic [INSTR_WIDTH-1:0] head_data;
    logic                   handshake, redirect, resp_push, space_free, req;

    assign handshake = instr_valid && instr_ready;
    assign redirect  = handshake && PC_select;
    // A redirect discards the response landing on the same edge.
    assign resp_push = inflight_q && !drop_q && !redirect;
    // Room for one more request counting both buffered and in-flight entries.
    assign space_free = !buf_full && !(inflight_q && (buf_count == CW'(DEPTH-1)));
    // A pop this cycle frees a slot, which keeps throughput at one per cycle.
    assign req = (state_q == S_RUN) && (handshake || space_free);

    assign instr_req   = req;
    assign instr_addr  = fetch_pc_q;
    assign instr_valid = !buf_empty;
    assign instruction = buf_empty ? hold_instr_q : head_data;
    assign instr_PC    = buf_empty ? hold_pc_q : head_addr;
    assign opcode      = instruction[INSTR_WIDTH-1 -: OPCODE_WIDTH];

    fetch_buffer #(
        .DEPTH (DEPTH),
        .AW    (ADDR_WIDTH),
        .IW    (INSTR_WIDTH)
    ) u_buf (
        .clock     (clock),
        .reset     (reset),
        .push      (resp_push),
        .pop       (handshake),
        .clear     (redirect),
        .push_addr (inflight_addr_q),
        .push_data (instr_rdata),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count),
        .head_addr (head_addr),
        .head_data (head_data)
    );

    // Next-state for the sequencer, fetch PC, in-flight tracking and head hold.
    always_comb begin
        state_d         = state_q;
        fetch_pc_d      = fetch_pc_q;
        inflight_d      = req;
        inflight_addr_d = fetch_pc_q;
        drop_d          = redirect;
        hold_instr_d    = hold_instr_q;
        hold_pc_d       = hold_pc_q;

        if (redirect)  fetch_pc_d = jump_target;
        else if (req)  fetch_pc_d = fetch_pc_q + 1'b1;

        case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN:   if (redirect) state_d = S_FLUSH;
            S_FLUSH: state_d = S_RUN;
            default: state_d = S_BOOT;
        endcase

        if (!buf_empty) begin
            hold_instr_d = head_data;
            hold_pc_d    = head_addr;
        end
    end

    // All fetch-side registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= S_BOOT;
            fetch_pc_q      <= RESET_PC;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
            drop_q          <= 1'b0;
            hold_instr_q    <= '0;
            hold_pc_q       <= '0;
        end else begin
            state_q         <= state_d;
            fetch_pc_q      <= fetch_pc_d;
            inflight_q      <= inflight_d;
            inflight_addr_q <= inflight_addr_d;
            drop_q          <= drop_d;
            hold_instr_q    <= hold_instr_d;
            hold_pc_q       <= hold_pc_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [15:0] fetch_count_q, fetch_count_d;
    logic [15:0] flush_count_q, flush_count_d;

    // Saturating counts of buffered instructions and redirects.
    always_comb begin
        fetch_count_d = sat_inc16(fetch_count_q, resp_push);
        flush_count_d = sat_inc16(flush_count_q, redirect);
    end

    // Performance counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign flush_count = flush_count_q;
`endif

endmodule
